// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and open-drain PS/2 pin signals for the host-to-device transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       rx_inhibit;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;

   modport master (
      output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
      input  tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe
   );

   modport slave (
      input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
      output tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts out a byte with
// odd parity on device clock falls, checks the device ACK and guards the frame with a timeout.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 420,
   parameter int unsigned TIMEOUT_CYCLES = 52500,
   parameter int unsigned FILTER_LEN     = 4
) (
   input logic          clk,
   input logic          reset,
   ps2_host_tx_if.slave bus
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned FltW = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {StIdle, StInhibit, StReq, StAck, StWaitIdle} state_e;

   state_e          state_q, state_d;
   logic [7:0]      sh_q, sh_d;
   logic            par_q, par_d;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic            clk_oe_q, clk_oe_d;
   logic            dat_oe_q, dat_oe_d;
   logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic            filt_q, filt_d;
   logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
   logic            fall, timeout, done, err, in_frame;

   // Filtered CLK flips only after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FltW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
      fall = filt_q & ~filt_d;
   end

   assign in_frame = (state_q == StReq) || (state_q == StAck) || (state_q == StWaitIdle);
   assign timeout  = in_frame && (to_cnt_q == ToW'(TIMEOUT_CYCLES));

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      par_d     = par_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      bit_cnt_d = bit_cnt_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      done      = 1'b0;
      err       = 1'b0;
      if (in_frame && !timeout) to_cnt_d = to_cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (bus.tx_valid) begin
               sh_d      = bus.tx_data;
               par_d     = ~^bus.tx_data;
               inh_cnt_d = '0;
               bit_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = StInhibit;
            end
         end
         StInhibit: begin
            inh_cnt_d = inh_cnt_q + 1'b1;
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 2)) dat_oe_d = 1'b1;
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               to_cnt_d = '0;
               state_d  = StReq;
            end
         end
         StReq: begin
            if (fall) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q < 4'd8) begin
                  dat_oe_d = ~sh_q[bit_cnt_q[2:0]];
               end else if (bit_cnt_q == 4'd8) begin
                  dat_oe_d = ~par_q;
               end else begin
                  dat_oe_d = 1'b0;
                  state_d  = StAck;
               end
            end
         end
         StAck: begin
            if (fall) begin
               if (dat_s2_q) begin
                  err     = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            if (dat_s2_q && filt_q) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Timeout overrides whatever the frame was doing this clk, including a coincident ACK fall.
      if (timeout) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         done     = 1'b0;
         err      = 1'b1;
         state_d  = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         sh_q      <= '0;
         par_q     <= 1'b0;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         bit_cnt_q <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         filt_q    <= 1'b1;
         flt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         par_q     <= par_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         clk_s1_q  <= bus.ps2_clk_in;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= bus.ps2_dat_in;
         dat_s2_q  <= dat_s1_q;
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   assign bus.tx_ready   = (state_q == StIdle);
   assign bus.rx_inhibit = (state_q != StIdle);
   assign bus.tx_done    = done;
   assign bus.tx_error   = err;
   assign bus.ps2_clk_oe = clk_oe_q;
   assign bus.ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND PS/2 lines with a clocking device model and a frame reference.
module tb_ps2_host_tx;
   localparam int HALF = 30;

   logic clk;
   logic reset;
   logic dev_clk_low;
   logic dev_dat_low;
   int   checks;
   int   errors;
   int   done_cnt;
   int   err_cnt;
   int   bad_cnt;

   ps2_host_tx_if bus_if ();

   ps2_host_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   // Open-drain lines: low if either side pulls.
   assign bus_if.ps2_clk_in = ~(bus_if.ps2_clk_oe | dev_clk_low);
   assign bus_if.ps2_dat_in = ~(bus_if.ps2_dat_oe | dev_dat_low);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus_if.tx_error === 1'b1) err_cnt <= err_cnt + 1;
      if ((bus_if.tx_done === 1'b1 && bus_if.tx_error === 1'b1) ||
          (bus_if.ps2_clk_oe === 1'b1 && bus_if.rx_inhibit !== 1'b1))
         bad_cnt <= bad_cnt + 1;
   end

   // Reference: start 0, data LSB first, odd parity, stop 1 (bit 0 is the first on the wire).
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic p;
      p = ($countones(d) % 2 == 0);
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] d);
      int w;
      w = 0;
      while (bus_if.tx_ready !== 1'b1 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 5000) begin
         errors++;
         $display("FAIL send_ready: tx_ready=%b after %0d clks, required 1", bus_if.tx_ready, w);
      end
      bus_if.tx_data  = d;
      bus_if.tx_valid = 1'b1;
      @(negedge clk);
      bus_if.tx_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (bus_if.tx_ready !== 1'b1 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 5000) begin
         errors++;
         $display("FAIL end_ready: tx_ready=%b after %0d clks, required 1", bus_if.tx_ready, w);
      end
      repeat (2) @(negedge clk);
   endtask

   // Device: waits for request-to-send, clocks n_clk times, samples DAT before each rising edge.
   task automatic device_run(input int n_clk, input bit ack, input int glitch_idx,
                             output logic [10:0] seen);
      int w;
      seen = 'x;
      w    = 0;
      while ((bus_if.ps2_clk_oe !== 1'b0 || bus_if.ps2_dat_in !== 1'b0) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 2000) begin
         errors++;
         $display("FAIL rts_wait: clk_oe=%b dat=%b, required 0 0", bus_if.ps2_clk_oe,
                  bus_if.ps2_dat_in);
         return;
      end
      seen[0] = bus_if.ps2_dat_in;
      for (int i = 1; i <= n_clk; i++) begin
         repeat (HALF) @(negedge clk);
         if (i == glitch_idx) begin
            dev_clk_low     = 1'b1;
            bus_if.tx_valid = 1'b1;
            bus_if.tx_data  = 8'($urandom);
            repeat (2) @(negedge clk);
            dev_clk_low     = 1'b0;
            bus_if.tx_valid = 1'b0;
            repeat (HALF) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         if (i <= 10) seen[i] = bus_if.ps2_dat_in;
         dev_clk_low = 1'b0;
         if (i == 10 && ack) dev_dat_low = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      dev_dat_low = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_if.ps2_clk_oe, bus_if.ps2_dat_oe, bus_if.tx_done, bus_if.tx_error} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_out: oe/done/err=%b, required 0000", {bus_if.ps2_clk_oe,
                  bus_if.ps2_dat_oe, bus_if.tx_done, bus_if.tx_error});
      end
      checks++;
      if ({bus_if.tx_ready, bus_if.rx_inhibit} !== 2'b10) begin
         errors++;
         $display("FAIL reset_ready: ready/inhibit=%b, required 10",
                  {bus_if.tx_ready, bus_if.rx_inhibit});
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_send_ed();
      logic [10:0] seen;
      int d0, e0, n, nd;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hED);
      n  = 0;
      nd = 0;
      while (bus_if.ps2_clk_oe === 1'b1 && n < 2000) begin
         if (bus_if.ps2_dat_oe === 1'b1) nd++;
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 420) begin
         errors++;
         $display("FAIL inhibit_len: clk low %0d clks, required 420", n);
      end
      checks++;
      if (nd != 1) begin
         errors++;
         $display("FAIL start_lead: dat low %0d clks inside inhibit, required 1", nd);
      end
      checks++;
      if (bus_if.ps2_dat_oe !== 1'b1) begin
         errors++;
         $display("FAIL start_bit: dat_oe=%b at clk release, required 1", bus_if.ps2_dat_oe);
      end
      device_run(11, 1'b1, 0, seen);
      checks++;
      if (seen !== frame_of(8'hED)) begin
         errors++;
         $display("FAIL frame_ed: saw %b, required %b", seen, frame_of(8'hED));
      end
      wait_ready();
      checks++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         errors++;
         $display("FAIL pulses_ed: done %0d err %0d, required 1 0", done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if ({bus_if.ps2_clk_oe, bus_if.ps2_dat_oe} !== 2'b00) begin
         errors++;
         $display("FAIL release_ed: oe=%b, required 00",
                  {bus_if.ps2_clk_oe, bus_if.ps2_dat_oe});
      end
   endtask

   task automatic test_parity();
      logic [7:0]  bytes [6];
      logic [10:0] seen;
      int d0, e0;
      bytes[0] = 8'h07;
      bytes[1] = 8'h00;
      for (int i = 2; i < 6; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         send_byte(bytes[i]);
         device_run(11, 1'b1, 0, seen);
         checks++;
         if (seen !== frame_of(bytes[i])) begin
            errors++;
            $display("FAIL frame_%02h: saw %b, required %b", bytes[i], seen, frame_of(bytes[i]));
         end
         wait_ready();
         checks++;
         if (done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL pulses_%02h: done %0d err %0d, required 1 0", bytes[i],
                     done_cnt - d0, err_cnt - e0);
         end
      end
   endtask

   task automatic test_no_ack();
      logic [7:0]  d;
      logic [10:0] seen;
      int d0, e0;
      d  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(d);
      device_run(11, 1'b0, 0, seen);
      wait_ready();
      checks++;
      if (err_cnt - e0 != 1 || done_cnt != d0) begin
         errors++;
         $display("FAIL no_ack_pulses: done %0d err %0d, required 0 1", done_cnt - d0,
                  err_cnt - e0);
      end
      checks++;
      if ({bus_if.ps2_clk_oe, bus_if.ps2_dat_oe} !== 2'b00) begin
         errors++;
         $display("FAIL no_ack_release: oe=%b, required 00",
                  {bus_if.ps2_clk_oe, bus_if.ps2_dat_oe});
      end
   endtask

   task automatic test_timeout();
      int d0, e0, n, w;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hFF);
      w = 0;
      while (bus_if.ps2_clk_oe !== 1'b0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      n = 0;
      while (bus_if.tx_error !== 1'b1 && n < 60000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 52500) begin
         errors++;
         $display("FAIL timeout_len: tx_error after %0d clks, required 52500", n);
      end
      @(negedge clk);
      checks++;
      if ({bus_if.ps2_clk_oe, bus_if.ps2_dat_oe, bus_if.tx_ready} !== 3'b001) begin
         errors++;
         $display("FAIL timeout_release: oe/ready=%b, required 001",
                  {bus_if.ps2_clk_oe, bus_if.ps2_dat_oe, bus_if.tx_ready});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1 || done_cnt != d0) begin
         errors++;
         $display("FAIL timeout_pulses: done %0d err %0d, required 0 1", done_cnt - d0,
                  err_cnt - e0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  d;
      logic [10:0] seen;
      int d0, e0;
      d = 8'($urandom) & 8'hFB;
      send_byte(d);
      device_run(3, 1'b0, 0, seen);
      checks++;
      if ({bus_if.ps2_dat_oe, bus_if.rx_inhibit} !== 2'b11) begin
         errors++;
         $display("FAIL mid_frame: dat_oe/inhibit=%b, required 11",
                  {bus_if.ps2_dat_oe, bus_if.rx_inhibit});
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_if.ps2_clk_oe, bus_if.ps2_dat_oe, bus_if.tx_ready} !== 3'b001) begin
         errors++;
         $display("FAIL mid_reset: oe/ready=%b, required 001",
                  {bus_if.ps2_clk_oe, bus_if.ps2_dat_oe, bus_if.tx_ready});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      d  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(d);
      device_run(11, 1'b1, 0, seen);
      checks++;
      if (seen !== frame_of(d)) begin
         errors++;
         $display("FAIL post_reset_frame: saw %b, required %b", seen, frame_of(d));
      end
      wait_ready();
      checks++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         errors++;
         $display("FAIL post_reset_pulses: done %0d err %0d, required 1 0", done_cnt - d0,
                  err_cnt - e0);
      end
   endtask

   task automatic test_glitch();
      logic [7:0]  d;
      logic [10:0] seen;
      int d0, e0, n_oe;
      d  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(d);
      device_run(11, 1'b1, 5, seen);
      checks++;
      if (seen !== frame_of(d)) begin
         errors++;
         $display("FAIL glitch_frame: saw %b, required %b", seen, frame_of(d));
      end
      wait_ready();
      n_oe = 0;
      for (int i = 0; i < 1000; i++) begin
         if (bus_if.ps2_clk_oe !== 1'b0 || bus_if.rx_inhibit !== 1'b0) n_oe++;
         @(negedge clk);
      end
      checks++;
      if (n_oe != 0) begin
         errors++;
         $display("FAIL glitch_no_requeue: %0d busy clks after frame, required 0", n_oe);
      end
      checks++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         errors++;
         $display("FAIL glitch_pulses: done %0d err %0d, required 1 0", done_cnt - d0,
                  err_cnt - e0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "stalled");
   end

   initial begin
      checks          = 0;
      errors          = 0;
      done_cnt        = 0;
      err_cnt         = 0;
      bad_cnt         = 0;
      dev_clk_low     = 1'b0;
      dev_dat_low     = 1'b0;
      bus_if.tx_valid = 1'b0;
      bus_if.tx_data  = 8'h00;
      reset           = 1'b0;
      test_reset();
      test_send_ed();
      test_parity();
      test_no_ack();
      test_timeout();
      test_reset_mid();
      test_glitch();
      checks++;
      if (bad_cnt != 0) begin
         errors++;
         $display("FAIL line_rules: %0d bad clks, required 0", bad_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
